nibble_serial_adder: RTL
========================

Name: nibble_serial_adder

Overview:
- Sequential multi-word adder: accepts two W-bit operands plus carry-in over a valid/ready handshake.
- Adds them one 4-bit nibble per cycle, LSB nibble first, rippling the carry through a register.
- Returns the W-bit sum and carry-out over a valid/ready handshake.
- Sits directly around the 4-bit ripple-add datapath: it feeds nibble operands and carry into the adder and consumes its sum/carry outputs. This gives wide additions without a wide combinational ripple chain.

Parameters:
- NIBBLES, 4, number of 4-bit nibbles per operand (>=1); W = 4*NIBBLES, 16 by default.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand set present.
- in_ready  output  1  block can accept operands this cycle.
- a  input  W  operand A.
- b  input  W  operand B.
- cin  input  1  carry-in to nibble 0.
- out_valid  output  1  result present.
- out_ready  input  1  consumer takes result this cycle.
- sum  output  W  result, a+b+cin mod 2^W.
- cout  output  1  carry out of the top nibble.
- busy  output  1  high in RUN state.

Behaviour:
- Reset (asynchronous, active-high, takes effect immediately):
  - state=IDLE; out_valid=0, sum=0, cout=0, busy=0.
  - Nibble index, carry register and operand registers cleared.
  - in_ready=1 once rst deasserts.
- States: IDLE, RUN, DONE.
- in_ready = (state==IDLE) || (state==DONE && out_ready). It is combinational from state and out_ready.
- Accept = in_valid && in_ready, sampled at a rising edge:
  - a, b latched into internal registers; carry_r <= cin; idx <= 0; next state RUN.
  - Inputs a/b/cin may change freely after the accept edge without affecting the result.
- RUN, each edge:
  - nibble idx computed as a[4idx+3:4idx] + b[4idx+3:4idx] + carry_r.
  - 4-bit result written to sum[4idx+3:4idx]; carry_r <= nibble carry-out; idx <= idx+1.
  - On the edge where idx==NIBBLES-1: cout <= nibble carry-out; state -> DONE.
  - busy=1 throughout RUN.
- Latency: accept at edge k -> out_valid=1 after edge k+NIBBLES. NIBBLES=1 gives one RUN cycle.
- DONE:
  - out_valid=1; sum and cout held stable until handshake.
  - out_valid && out_ready at an edge: result consumed.
  - If in_valid is also high at that edge, the new operands are accepted in the same edge and the next state is RUN (back-to-back). Otherwise the next state is IDLE.
- out_valid deasserts on any edge where the handshake completes without a new accept. Once asserted, it never drops without a handshake or reset.
- sum content while out_valid=0 is unspecified (partial result); the bench checks sum/cout only when out_valid=1.
- in_valid during RUN, or during DONE without out_ready, is ignored; the upstream must hold operands until in_ready.
- Arithmetic: unsigned, modulo 2^W. The carry chain is exact across nibble boundaries: all 1s + 1 ripples through every nibble.
- idx width: max(1, $clog2(NIBBLES)); no wrap beyond NIBBLES-1.
- Reset mid-RUN or mid-DONE: operation aborted, no out_valid pulse, result discarded.

Decomposition:
- Shared package holds:
  - NIBBLE_W=4 constant.
  - State enum: IDLE, RUN, DONE.
  - Helper function for idx width.
- One sub-module, nibble_add_ci: combinational 4-bit ripple adder with carry-in and carry-out. It is built from per-bit full adders (and/or carry, xor sum), instantiated once, and shared across cycles via the operand nibble mux.

Test Plan:
1. NIBBLES=4; a=0x1234, b=0x1111, cin=0, out_ready=1 -> sum=0x2345, cout=0; out_valid exactly 4 edges after the accept edge, busy high for 4 cycles.
2. a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1 (carry ripples through all four nibbles); repeat with a=0xFFFF, b=0xFFFF, cin=1 -> sum=0xFFFF, cout=1.
3. Backpressure: result 0x00F0+0x0010=0x0100 held with out_ready=0 for 5 cycles -> out_valid, sum=0x0100, cout=0 stable; in_ready=0; an in_valid pulse in that window is ignored.
4. Back-to-back: in DONE with out_ready=1 and in_valid=1 (a=0x0F0F, b=0x00F1, cin=0) -> both handshakes on the same edge; no IDLE cycle; next sum=0x1000, cout=0 four edges later.
5. Operand stability: change a/b/cin to random values on the edge after accept -> result still matches the latched operands.
6. Reset mid-RUN: assert rst 2 cycles into an add -> out_valid=0, sum=0, cout=0 immediately (asynchronous); after release in_ready=1; next op 0x8000+0x8000 -> sum=0x0000, cout=1.

Source files
------------

// File: rtl/nibble_serial_adder_pkg.sv
// Shared constants, state encoding and sizing helper for the nibble-serial adder.
package nibble_serial_adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int idx_width(input int nibbles);
        return (nibbles <= 1) ? 1 : $clog2(nibbles);
    endfunction

endpackage

// File: rtl/nibble_add_ci.sv
// Combinational 4-bit ripple adder built from per-bit full adders.
module nibble_add_ci
    import nibble_serial_adder_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a_i,
    input  logic [NIBBLE_W-1:0] b_i,
    input  logic                ci_i,
    output logic [NIBBLE_W-1:0] s_o,
    output logic                co_o
);

    logic [NIBBLE_W:0] c;

    assign c[0] = ci_i;

    for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
        logic p;
        assign p      = a_i[i] ^ b_i[i];
        assign s_o[i] = p ^ c[i];
        assign c[i+1] = (a_i[i] & b_i[i]) | (p & c[i]);
    end

    assign co_o = c[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-word adder that reuses one 4-bit ripple adder, one nibble per cycle, LSB first.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | waiting for operands, in_ready high
//   RUN     | adding nibble idx, carry held in carry_q, busy high
//   DONE    | result valid, held until out_ready; may accept next operands
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [NIBBLE_W*NIBBLES-1:0] a,
    input  logic [NIBBLE_W*NIBBLES-1:0] b,
    input  logic                        cin,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [NIBBLE_W*NIBBLES-1:0] sum,
    output logic                        cout,
    output logic                        busy
);

    localparam int W  = NIBBLE_W * NIBBLES;
    localparam int IW = idx_width(NIBBLES);
    localparam logic [IW-1:0] IDX_LAST = IW'(NIBBLES - 1);

    state_e          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            carry_q, carry_d;
    logic            cout_q, cout_d;
    logic [IW-1:0]   idx_q, idx_d;

    logic [NIBBLE_W-1:0] nib_a, nib_b, nib_sum;
    logic                nib_cout;
    logic                accept;

    assign nib_a = a_q[int'(idx_q)*NIBBLE_W +: NIBBLE_W];
    assign nib_b = b_q[int'(idx_q)*NIBBLE_W +: NIBBLE_W];

    nibble_add_ci u_add (
        .a_i  (nib_a),
        .b_i  (nib_b),
        .ci_i (carry_q),
        .s_o  (nib_sum),
        .co_o (nib_cout)
    );

    assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q == ST_RUN);
    assign sum       = sum_q;
    assign cout      = cout_q;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        idx_d   = idx_q;

        case (state_q)
            ST_IDLE: ;
            ST_RUN: begin
                sum_d[int'(idx_q)*NIBBLE_W +: NIBBLE_W] = nib_sum;
                carry_d = nib_cout;
                if (idx_q == IDX_LAST) begin
                    cout_d  = nib_cout;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Accept overrides the DONE->IDLE exit so back-to-back ops skip IDLE.
        if (accept) begin
            a_d     = a;
            b_d     = b;
            carry_d = cin;
            idx_d   = '0;
            state_d = ST_RUN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            idx_q   <= idx_d;
        end
    end

endmodule
